// File: rtl/window_compare_stats_if.sv
// Handshake and result bundle for window_compare_stats.
// master drives samples/start/out_ready; slave is the statistics stage.
interface window_compare_stats_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] threshold;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] eq_count;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic             busy;

  modport master (
    output start, threshold, in_valid, in_data, out_ready,
    input  in_ready, out_valid, gt_count, lt_count, eq_count, max_val, min_val, busy
  );

  modport slave (
    input  start, threshold, in_valid, in_data, out_ready,
    output in_ready, out_valid, gt_count, lt_count, eq_count, max_val, min_val, busy
  );
endinterface

// File: rtl/window_compare_stats.sv
// Windowed threshold-compare statistics (gt/lt/eq counts, running max/min).
// Define WCS_COUNT_SAT_EN for saturating outcome counters; default build wraps.
module window_compare_stats #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16
) (
  input logic                    clk,
  input logic                    rst,
  window_compare_stats_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [15:0]      scnt_q, scnt_d;

  logic accept;
  logic last;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef WCS_COUNT_SAT_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  assign accept = (state_q == StRun) && bus.in_valid;
  // scnt_q holds the number of samples already accepted in this window.
  assign last   = (scnt_q == 16'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    max_d   = max_q;
    min_d   = min_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          thr_d   = bus.threshold;
          gt_d    = '0;
          lt_d    = '0;
          eq_d    = '0;
          max_d   = '0;
          min_d   = '0;
          scnt_d  = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (bus.in_data > thr_q) begin
            gt_d = bump(gt_q);
          end else if (bus.in_data < thr_q) begin
            lt_d = bump(lt_q);
          end else begin
            eq_d = bump(eq_q);
          end
          if (scnt_q == '0) begin
            max_d = bus.in_data;
            min_d = bus.in_data;
          end else begin
            if (bus.in_data > max_q) max_d = bus.in_data;
            if (bus.in_data < min_q) min_d = bus.in_data;
          end
          scnt_d = scnt_q + 16'd1;
          if (last) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      thr_q   <= '0;
      gt_q    <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      max_q   <= '0;
      min_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      max_q   <= max_d;
      min_q   <= min_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun) || (state_q == StDone);
  assign bus.gt_count  = gt_q;
  assign bus.lt_count  = lt_q;
  assign bus.eq_count  = eq_q;
  assign bus.max_val   = max_q;
  assign bus.min_val   = min_q;

endmodule

// File: doc/window_compare_stats.md
# window_compare_stats

Windowed statistics stage that sits directly downstream of the four-bit magnitude comparator. It accepts a stream of unsigned samples over a valid/ready handshake and compares each one against a threshold captured at window start. Over a fixed-length window it counts greater, less and equal outcomes and tracks the running maximum and minimum. When the window closes it presents the results to the consumer through a valid/ready handshake.

## Interface
- WIDTH, 4: sample and threshold width in bits (unsigned).
- CNT_W, 8: width of each outcome counter.
- WINDOW, 16: number of accepted samples per window; legal range 1 to 2^16-1.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to open a window; honoured only in IDLE.
- threshold  in  WIDTH  compare reference; captured on the cycle start is honoured.
- in_valid  in  1  sample present on in_data.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  high only in RUN.
- out_valid  out  1  high only in DONE.
- out_ready  in  1  consumer accepts results.
- gt_count  out  CNT_W  samples strictly greater than threshold.
- lt_count  out  CNT_W  samples strictly less than threshold.
- eq_count  out  CNT_W  samples equal to threshold.
- max_val  out  WIDTH  largest sample accepted in the window.
- min_val  out  WIDTH  smallest sample accepted in the window.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start: capture threshold; clear all counters, max_val, min_val and the internal sample counter; go to RUN.
  - When start is low, stay in IDLE.
- RUN:
  - A sample is accepted when in_valid and in_ready are both high.
  - For each accepted sample, do an unsigned compare against the captured threshold and increment exactly one of gt_count, lt_count or eq_count.
  - The first accepted sample loads both max_val and min_val. Each later sample updates max_val if it is greater than max_val and min_val if it is less than min_val.
  - When the WINDOW-th sample is accepted, go to DONE.
- DONE:
  - Hold all outputs stable while out_ready is low.
  - When out_ready is high, go to IDLE.
  - Outputs keep their values in IDLE until the next start.
- start is ignored in RUN and in DONE, including in the same cycle as the out_ready handshake.
- The internal sample counter is 16 bits. It is independent of CNT_W and is never affected by the configuration macro.
- Reset, including mid-window or mid-DONE:
  - State returns to IDLE immediately.
  - All outputs go to 0: counters, max_val, min_val, in_ready, out_valid, busy.
  - The captured threshold is cleared.

## Timing
- start honoured at edge N: in_ready and busy are high from cycle N+1.
- Sample accepted at edge N: the counter, max_val and min_val updates are visible at cycle N+1.
- Final sample accepted at edge N: in_ready is low and out_valid is high from cycle N+1. No extra latency cycle is allowed.
- out_valid and out_ready both high at edge N: out_valid, in_ready and busy are low at N+1, and the FSM is in IDLE.
- Fastest back-to-back window: start can be honoured one cycle after the DONE handshake.
- in_valid gaps in RUN stall the window with no state change. The window has no timeout.
- Minimum window length is WINDOW+2 cycles from start to IDLE, with in_valid and out_ready held high.

## Configuration
- WCS_COUNT_SAT_EN: selects how outcome counters behave when they exceed their range.
- Defined: each outcome counter saturates at 2^CNT_W-1 and holds there for the rest of the window.
- Undefined: each outcome counter wraps modulo 2^CNT_W.
- The sample counter, the WINDOW termination point and max/min tracking are identical in both builds.

## Test plan
- Basic window:
  - Stimulus: WINDOW=4, threshold=5, samples 3, 5, 9, 5 with no gaps.
  - Required: gt=1, lt=1, eq=2, max=9, min=3; out_valid rises the cycle after the 4th handshake.
- Backpressure both sides:
  - Stimulus: same as basic window, with in_valid dropping for 2 cycles between samples; out_ready held low for 5 cycles in DONE.
  - Required: results unchanged; outputs stable through the stall; in_ready stays 0 in DONE.
- Ignored start:
  - Stimulus: pulse start with threshold=0 mid-RUN and again in the DONE handshake cycle.
  - Required: threshold stays 5; counts unaffected; the FSM goes to IDLE after DONE, not to RUN.
- Mid-window reset:
  - Stimulus: assert rst after 2 of 4 samples.
  - Required: all outputs read 0 in the same cycle; after release, a new start runs a clean window with correct counts.
- Saturate vs wrap:
  - Stimulus: CNT_W=2, WINDOW=5, threshold=0, five samples of 15.
  - Required: gt_count=3 with WCS_COUNT_SAT_EN defined and 1 without; out_valid after exactly 5 handshakes in both builds.
- Single-sample window:
  - Stimulus: WINDOW=1, threshold=15, sample 15.
  - Required: eq=1, max=min=15; DONE the cycle after the handshake.
